// File: rtl/crypto_wallet2_seed_pkg.sv
// crypto_wallet2_seed_pkg: shared FSM state type and widths for the seed writer
package crypto_wallet2_seed_pkg;
    localparam int SEED_W = 32;
    localparam int BIT_CNT_W = 6;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_READ    = 2'd3
    } state_t;
endpackage

// File: rtl/crypto_wallet2_vn_debias.sv
// crypto_wallet2_vn_debias: entropy synchronizer, sample divider and von Neumann pair debiaser
module crypto_wallet2_vn_debias #(
    parameter int SAMPLE_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic entropy_in,
    output logic bit_valid,
    output logic bit_val
);
    logic [1:0] sync;
    logic [7:0] tick_cnt;
    logic       tick;
    logic       have_first;
    logic       first;
    assign tick      = tick_cnt == 8'(SAMPLE_DIV - 1);
    assign bit_valid = tick && have_first && (first != sync[1]);
    assign bit_val   = first;
    // the synchronizer runs freely so samples are valid from the first tick
    always_ff @(posedge clk or posedge reset)
        if (reset) sync <= '0;
        else sync <= {sync[0], entropy_in};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt   <= '0;
            have_first <= 1'b0;
            first      <= 1'b0;
        end else if (clear) begin
            tick_cnt   <= '0;
            have_first <= 1'b0;
            first      <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 8'd1;
            if (tick) begin
                have_first <= !have_first;
                if (!have_first) first <= sync[1];
            end
        end
    end
endmodule

// File: rtl/crypto_wallet2_seed_writer.sv
// crypto_wallet2_seed_writer: harvests a debiased 32-bit seed and writes it over Avalon-MM; SEED_READBACK_EN adds read verification
module crypto_wallet2_seed_writer
    import crypto_wallet2_seed_pkg::*;
#(
    parameter int SEED_ADDR  = 0,
    parameter int ADDR_W     = 2,
    parameter int SAMPLE_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              entropy_in,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic              read_n,
    output logic [SEED_W-1:0] writedata,
    input  logic [SEED_W-1:0] readdata,
    input  logic              waitrequest,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        seed_count
);
    state_t                 state;
    logic [SEED_W-1:0]      shreg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   bit_valid;
    logic                   bit_val;
    logic                   accept;
    crypto_wallet2_vn_debias #(.SAMPLE_DIV(SAMPLE_DIV)) u_debias (
        .clk        (clk),
        .reset      (reset),
        .clear      (state != ST_COLLECT),
        .entropy_in (entropy_in),
        .bit_valid  (bit_valid),
        .bit_val    (bit_val)
    );
    // strobes decode straight from state so an async reset drops them at once
    assign address    = ADDR_W'(SEED_ADDR);
    assign chipselect = (state == ST_WRITE) || (state == ST_READ);
    assign write_n    = state != ST_WRITE;
    assign busy       = state != ST_IDLE;
    assign accept     = (state == ST_IDLE) && start && !done;
`ifdef SEED_READBACK_EN
    logic err_q;
    assign error  = err_q;
    assign read_n = state != ST_READ;
`else
    logic unused_readdata;
    assign unused_readdata = ^readdata;
    assign error  = 1'b0;
    assign read_n = 1'b1;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            writedata  <= '0;
            done       <= 1'b0;
            seed_count <= '0;
`ifdef SEED_READBACK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    state   <= ST_COLLECT;
                    shreg   <= '0;
                    bit_cnt <= '0;
`ifdef SEED_READBACK_EN
                    err_q   <= 1'b0;
`endif
                end
                ST_COLLECT: if (bit_valid) begin
                    shreg   <= {shreg[SEED_W-2:0], bit_val};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BIT_CNT_W'(SEED_W - 1)) begin
                        state     <= ST_WRITE;
                        writedata <= {shreg[SEED_W-2:0], bit_val};
                    end
                end
                ST_WRITE: if (!waitrequest) begin
                    seed_count <= seed_count + 8'd1;
`ifdef SEED_READBACK_EN
                    state      <= ST_READ;
`else
                    state      <= ST_IDLE;
                    done       <= 1'b1;
`endif
                end
`ifdef SEED_READBACK_EN
                ST_READ: if (!waitrequest) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                    err_q <= readdata != writedata;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/crypto_wallet2_seed_writer.md
# crypto_wallet2_seed_writer

Avalon-MM master that harvests a 32-bit random seed from a raw noise input and writes it into the seed PIO slave register. On a start request it samples and von-Neumann-debiases an asynchronous entropy bit, assembles 32 bits, then performs one Avalon write of the seed with full `waitrequest` handshaking. It sits beside the Nios II data master in the crypto_wallet2 Qsys system, so a fresh seed reaches the wallet without CPU involvement.

## Interface
- `SEED_ADDR`, default 0: Avalon word address of the seed register.
- `ADDR_W`, default 2: width of `address`.
- `SAMPLE_DIV`, default 16: clock cycles between entropy samples; legal range 1..255.
- Reset is fixed: one clock, asynchronous active-high reset.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous reset, active-high.
- `entropy_in`  in  1  raw noise bit, asynchronous to `clk`.
- `start`  in  1  one-cycle request for a new seed; ignored while `busy`=1.
- `address`  out  ADDR_W  Avalon address; always `SEED_ADDR`.
- `chipselect`  out  1  Avalon transfer active.
- `write_n`  out  1  Avalon write strobe, active-low.
- `read_n`  out  1  Avalon read strobe, active-low; used only when readback is compiled in.
- `writedata`  out  32  seed being written.
- `readdata`  in  32  Avalon read data; valid in the cycle `waitrequest`=0.
- `waitrequest`  in  1  slave stall.
- `busy`  out  1  high from an accepted `start` until the `done` pulse.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky readback mismatch flag; cleared by the next accepted `start`.
- `seed_count`  out  8  count of seeds written; wraps 255 -> 0.

## Operation
- FSM states: IDLE, COLLECT, WRITE, READ (readback build only).
- IDLE -> COLLECT when `start`=1. On entry, clear the shift register, the bit counter and `error`.
- COLLECT behaviour:
  - `entropy_in` passes through a 2-flop synchronizer.
  - A tick counter issues one sample every `SAMPLE_DIV` cycles.
  - Samples pair up: (first, second) = (1,0) emits bit 1; (0,1) emits bit 0; (0,0) and (1,1) are discarded. Pairs never overlap.
  - Each emitted bit shifts into the LSB: `shreg <= {shreg[30:0], bit}`.
  - A 6-bit counter counts emitted bits. When it reaches 32, go to WRITE.
- WRITE: drive `chipselect`=1, `write_n`=0, `writedata`=shreg and hold them unchanged while `waitrequest`=1.
  - When `waitrequest`=0 the write is accepted: `seed_count` increments.
  - Next state is READ in the readback build, otherwise IDLE with `done`.
- READ: drive `chipselect`=1, `read_n`=0 until `waitrequest`=0. Then compare `readdata` with `writedata`, set `error` on mismatch, go to IDLE with `done`.
- Outside WRITE and READ, hold `chipselect`=0, `write_n`=1 and `read_n`=1.
- Reset values: `chipselect`=0, `write_n`=1, `read_n`=1, `writedata`=0, `busy`=0, `done`=0, `error`=0, `seed_count`=0; state is IDLE.
- Reset mid-transfer deasserts the bus strobes immediately (asynchronously). The partial seed is discarded.
- `start` asserted together with `done` is ignored.

## Timing
- Synchronizer latency: 2 cycles.
- First sample tick: `SAMPLE_DIV` cycles after entering COLLECT.
- Bus strobes assert in the cycle after the 32nd bit is shifted in.
- Minimum write duration is 1 cycle (when `waitrequest`=0 immediately).
- `done` is registered: it pulses in the cycle after the final transfer is accepted, and `busy` falls in the same cycle.
- `seed_count` updates in the cycle after write acceptance.
- Best-case latency from `start` to `done` with `SAMPLE_DIV`=1 and no discarded pairs: 1 + 64 + 1 + 1 cycles.

## Configuration
- `SEED_READBACK_EN`:
  - Defined: READ state exists, the write is verified by a read, and `error` is live.
  - Undefined: READ state is removed, `read_n` is tied to 1, and `error` is tied to 0.

## Structure
- Package `crypto_wallet2_seed_pkg` holds the FSM state enum, `SEED_W=32`, and `BIT_CNT_W=6`.
- Sub-module `crypto_wallet2_vn_debias` contains the synchronizer, the sample divider and the pair debiaser. It outputs `bit_valid` and `bit_val`, and is held cleared outside COLLECT.

## Test plan
- `SAMPLE_DIV`=1, `waitrequest`=0, synchronized entropy in repeating pairs (1,0),(0,1) -> `writedata`=0xAAAAAAAA, a single 1-cycle write to `SEED_ADDR`, `done` pulse, `seed_count`=1.
- Entropy constant 1 for 200 cycles, then pairs (1,0) -> no bits while the input is constant; final seed 0xFFFFFFFF.
- `waitrequest` held high for 5 cycles during WRITE -> `chipselect`, `write_n` and `writedata` are stable for all 6 cycles; exactly one increment of `seed_count`.
- With `SEED_READBACK_EN`, slave returns 0x12345678 when 0xAAAAAAAA was written -> `error`=1 at `done`; the next `start` clears it to 0.
- `reset` asserted in the first cycle of WRITE -> `chipselect`=0 and `write_n`=1 immediately; state IDLE, `busy`=0, `seed_count` unchanged.
- `start` pulsed during COLLECT and again in the `done` cycle -> both ignored; only one seed is written.
